// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg: types and constants shared by the GP0 command front-end.
//   - GP0 opcode constants (environment commands E1h-E6h, polygon range,
//     bypass ranges).
//   - Decoder state enum (IDLE, POLY, BYPASS).
//   - Opcode classification helpers.
package gpu_cmd_pkg;

  // Environment (register-bank) commands
  localparam logic [7:0] OP_TEXPAGE_E1  = 8'hE1;
  localparam logic [7:0] OP_TEXWINDOW   = 8'hE2;
  localparam logic [7:0] OP_DRAWAREA_TL = 8'hE3;
  localparam logic [7:0] OP_DRAWAREA_BR = 8'hE4;
  localparam logic [7:0] OP_E5_OFFSETS  = 8'hE5;
  localparam logic [7:0] OP_MASK        = 8'hE6;

  // Polygon command range
  localparam logic [7:0] OP_POLY_LO = 8'h20;
  localparam logic [7:0] OP_POLY_HI = 8'h3F;

  // Opcodes handed to the bypass engine
  localparam logic [7:0] OP_BYP_SINGLE = 8'h02;
  localparam logic [7:0] OP_BYP_LO     = 8'h40;
  localparam logic [7:0] OP_BYP_HI     = 8'hDF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POLY   = 2'd1,
    BYPASS = 2'd2
  } gp0State_t;

  function automatic logic isPolyOp(input logic [7:0] op);
    return (op >= OP_POLY_LO) && (op <= OP_POLY_HI);
  endfunction

  function automatic logic isBypassOp(input logic [7:0] op);
    return (op == OP_BYP_SINGLE) || ((op >= OP_BYP_LO) && (op <= OP_BYP_HI));
  endfunction

endpackage

// File: rtl/gp0_poly_len.sv
// gp0_poly_len: polygon command length decoder (purely combinational).
// Ports:
//   i_opBits      op[4:2] of a polygon opcode = {gouraud, quad, textured}
//   o_totalWords  number of FIFO words in the command, command word included
//   o_texIdx      0-based word index carrying the texpage (second vertex UV)
module gp0_poly_len
  import gpu_cmd_pkg::*;
(
  input  logic [2:0] i_opBits,
  output logic [3:0] o_totalWords,
  output logic [2:0] o_texIdx
);

  logic       gouraud;
  logic       quad;
  logic       textured;
  logic [3:0] nVert;

  assign gouraud  = i_opBits[2];
  assign quad     = i_opBits[1];
  assign textured = i_opBits[0];
  assign nVert    = quad ? 4'd4 : 4'd3;

  // Total = 1 + n*(1+t) + (n-1)*g; the first vertex colour rides in the
  // command word, hence (n-1) extra colour words for gouraud.
  always_comb begin
    o_totalWords = 4'd1 + (textured ? {nVert[2:0], 1'b0} : nVert)
                 + (gouraud ? (nVert - 4'd1) : 4'd0);
    if (gouraud) begin
      o_texIdx = 3'd5;
    end else begin
      o_texIdx = 3'd4;
    end
  end

endmodule

// File: rtl/gp0_cmd_decoder.sv
// gp0_cmd_decoder: GP0 command front-end.
// Pops words from the GP0 command FIFO, turns environment commands into
// one-cycle register-bank load strobes, streams polygon commands downstream
// and hands every other opcode to a bypass engine.
// Ports:
//   i_clk, nRstGPU             clock, asynchronous active-low reset
//   i_fifoEmpty, i_fifoData    FIFO status and FWFT head word
//   o_fifoPop                  consume the head word this cycle
//   fifoDataOut                registered copy of the last popped word
//   load*                      one-cycle strobes aligned with fifoDataOut
//   o_primValid/Data/First/Last, i_primReady   polygon word stream
//   o_bypassReq, i_bypassDone  bypass engine handshake
//   o_busy                     decoder is not idle
module gp0_cmd_decoder
  import gpu_cmd_pkg::*;
(
  input  logic        i_clk,
  input  logic        nRstGPU,
  input  logic        i_fifoEmpty,
  input  logic [31:0] i_fifoData,
  output logic        o_fifoPop,
  output logic [31:0] fifoDataOut,
  output logic        loadE5Offsets,
  output logic        loadTexPageE1,
  output logic        loadTexPage,
  output logic        loadTexWindowSetting,
  output logic        loadDrawAreaTL,
  output logic        loadDrawAreaBR,
  output logic        loadMaskSetting,
  output logic        o_primValid,
  output logic [31:0] o_primData,
  output logic        o_primFirst,
  output logic        o_primLast,
  input  logic        i_primReady,
  output logic        o_bypassReq,
  input  logic        i_bypassDone,
  output logic        o_busy
);

  gp0State_t  state;
  gp0State_t  stateNext;
  logic [3:0] remaining;
  logic [3:0] windex;
  logic       polyTex;
  logic [2:0] polyTexIdx;

  logic [7:0] headOp;
  logic [3:0] headTotal;
  logic [2:0] headTexIdx;
  logic       headIsPoly;
  logic       headIsBypass;

  logic       popS;
  logic       primValidS;
  logic       primFirstS;
  logic       primLastS;
  logic       bypassReqS;
  logic       popGated;

  assign headOp       = i_fifoData[31:24];
  assign headIsPoly   = isPolyOp(headOp);
  assign headIsBypass = isBypassOp(headOp);

  gp0_poly_len u_polyLen (
    .i_opBits     (headOp[4:2]),
    .o_totalWords (headTotal),
    .o_texIdx     (headTexIdx)
  );

  // Next-state and combinational handshake decode.
  always_comb begin
    stateNext  = state;
    popS       = 1'b0;
    primValidS = 1'b0;
    primFirstS = 1'b0;
    primLastS  = 1'b0;
    bypassReqS = 1'b0;
    case (state)
      IDLE: begin
        if (!i_fifoEmpty) begin
          if (headIsPoly) begin
            // The command word itself is the first word of the stream.
            primValidS = 1'b1;
            primFirstS = 1'b1;
            if (i_primReady) begin
              popS      = 1'b1;
              stateNext = POLY;
            end else begin
              popS = 1'b0;
            end
          end else if (headIsBypass) begin
            bypassReqS = 1'b1;
            stateNext  = BYPASS;
          end else begin
            // Environment commands and NOPs are consumed immediately.
            popS = 1'b1;
          end
        end else begin
          stateNext = IDLE;
        end
      end
      POLY: begin
        primValidS = !i_fifoEmpty;
        primLastS  = (remaining == 4'd1);
        if (primValidS && i_primReady) begin
          popS = 1'b1;
          if (remaining == 4'd1) begin
            stateNext = IDLE;
          end else begin
            stateNext = POLY;
          end
        end else begin
          popS = 1'b0;
        end
      end
      BYPASS: begin
        bypassReqS = 1'b1;
        if (i_bypassDone) begin
          stateNext = IDLE;
        end else begin
          stateNext = BYPASS;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Handshake outputs are forced low while reset is asserted so that a
  // reset mid-polygon silences the interface immediately.
  assign popGated    = popS & nRstGPU;
  assign o_fifoPop   = popGated;
  assign o_primValid = primValidS & nRstGPU;
  assign o_primFirst = primFirstS & nRstGPU;
  assign o_primLast  = primLastS & nRstGPU;
  assign o_bypassReq = bypassReqS & nRstGPU;
  assign o_primData  = nRstGPU ? i_fifoData : 32'h0000_0000;
  assign o_busy      = (state != IDLE);

  // State register.
  always_ff @(posedge i_clk or negedge nRstGPU) begin
    if (!nRstGPU) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Polygon word counters and latched texture attributes.
  always_ff @(posedge i_clk or negedge nRstGPU) begin
    if (!nRstGPU) begin
      remaining  <= 4'd0;
      windex     <= 4'd0;
      polyTex    <= 1'b0;
      polyTexIdx <= 3'd0;
    end else if (state == IDLE && popGated && headIsPoly) begin
      remaining  <= headTotal - 4'd1;
      windex     <= 4'd1;
      polyTex    <= headOp[2];
      polyTexIdx <= headTexIdx;
    end else if (state == POLY && popGated) begin
      remaining <= remaining - 4'd1;
      windex    <= windex + 4'd1;
    end
  end

  // Registered data copy and one-cycle load strobes.
  always_ff @(posedge i_clk or negedge nRstGPU) begin
    if (!nRstGPU) begin
      fifoDataOut          <= 32'h0000_0000;
      loadTexPageE1        <= 1'b0;
      loadTexWindowSetting <= 1'b0;
      loadDrawAreaTL       <= 1'b0;
      loadDrawAreaBR       <= 1'b0;
      loadE5Offsets        <= 1'b0;
      loadMaskSetting      <= 1'b0;
      loadTexPage          <= 1'b0;
    end else begin
      loadTexPageE1        <= 1'b0;
      loadTexWindowSetting <= 1'b0;
      loadDrawAreaTL       <= 1'b0;
      loadDrawAreaBR       <= 1'b0;
      loadE5Offsets        <= 1'b0;
      loadMaskSetting      <= 1'b0;
      loadTexPage          <= 1'b0;
      if (popGated) begin
        fifoDataOut <= i_fifoData;
      end
      if (state == IDLE && popGated) begin
        case (headOp)
          OP_TEXPAGE_E1:  loadTexPageE1        <= 1'b1;
          OP_TEXWINDOW:   loadTexWindowSetting <= 1'b1;
          OP_DRAWAREA_TL: loadDrawAreaTL       <= 1'b1;
          OP_DRAWAREA_BR: loadDrawAreaBR       <= 1'b1;
          OP_E5_OFFSETS:  loadE5Offsets        <= 1'b1;
          OP_MASK:        loadMaskSetting      <= 1'b1;
          default:        loadTexPage          <= 1'b0;
        endcase
      end
      // Texpage lives in the upper half of the second vertex's UV word.
      if (state == POLY && popGated && polyTex && (windex == {1'b0, polyTexIdx})) begin
        loadTexPage <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gp0_cmd_decoder.sv
// tb_gp0_cmd_decoder: directed self-checking bench for gp0_cmd_decoder.
// A queue stands in for the FWFT command FIFO; words leave it on every
// clock edge where the decoder asserted o_fifoPop.
module tb_gp0_cmd_decoder;

  logic        clk = 1'b0;
  logic        nRstGPU;
  logic        fifoEmpty;
  logic [31:0] fifoData;
  logic        fifoPop;
  logic [31:0] fifoDataOut;
  logic        loadE5Offsets, loadTexPageE1, loadTexPage, loadTexWindowSetting;
  logic        loadDrawAreaTL, loadDrawAreaBR, loadMaskSetting;
  logic        primValid;
  logic [31:0] primData;
  logic        primFirst, primLast;
  logic        primReady;
  logic        bypassReq;
  logic        bypassDone;
  logic        busy;

  logic [31:0] fifoQ[$];
  int          checks   = 0;
  int          failures = 0;

  // Strobe vector order: E1 E2 E3 E4 E5 E6 texpage
  logic [6:0]  strobes;
  assign strobes = {loadTexPageE1, loadTexWindowSetting, loadDrawAreaTL, loadDrawAreaBR,
                    loadE5Offsets, loadMaskSetting, loadTexPage};

  gp0_cmd_decoder dut (
    .i_clk                (clk),
    .nRstGPU              (nRstGPU),
    .i_fifoEmpty          (fifoEmpty),
    .i_fifoData           (fifoData),
    .o_fifoPop            (fifoPop),
    .fifoDataOut          (fifoDataOut),
    .loadE5Offsets        (loadE5Offsets),
    .loadTexPageE1        (loadTexPageE1),
    .loadTexPage          (loadTexPage),
    .loadTexWindowSetting (loadTexWindowSetting),
    .loadDrawAreaTL       (loadDrawAreaTL),
    .loadDrawAreaBR       (loadDrawAreaBR),
    .loadMaskSetting      (loadMaskSetting),
    .o_primValid          (primValid),
    .o_primData           (primData),
    .o_primFirst          (primFirst),
    .o_primLast           (primLast),
    .i_primReady          (primReady),
    .o_bypassReq          (bypassReq),
    .i_bypassDone         (bypassDone),
    .o_busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic driveFifo();
    fifoEmpty = (fifoQ.size() == 0);
    fifoData  = (fifoQ.size() == 0) ? 32'h0000_0000 : fifoQ[0];
  endtask

  // One clock: honour the pop seen before the edge, then settle inputs.
  task automatic stepCycle(input logic dropHead = 1'b0);
    logic popSeen;
    popSeen = fifoPop;
    @(posedge clk);
    if ((popSeen || dropHead) && fifoQ.size() > 0) void'(fifoQ.pop_front());
    #1;
    driveFifo();
    #1;
  endtask

  // Streams one polygon already queued; optional ready stall / FIFO gap.
  task automatic runPoly(input string name, input int total, input int texIdx,
                         input int stallAt, input int gapAt, input logic [31:0] rest[$]);
    logic [31:0] words[$];
    words = fifoQ;
    foreach (rest[i]) words.push_back(rest[i]);
    for (int k = 0; k < total; k++) begin
      if (k == stallAt) begin
        primReady = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
          checkValue({name, " stall pop"}, {31'd0, fifoPop}, 32'd0);
          checkValue({name, " stall data"}, primData, words[k]);
          stepCycle();
        end
        primReady = 1'b1;
        #1;
      end
      if (k == gapAt) begin
        for (int s = 0; s < 2; s++) begin
          checkValue({name, " gap valid/busy"}, {30'd0, primValid, busy}, 32'd1);
          stepCycle();
        end
        foreach (rest[i]) fifoQ.push_back(rest[i]);
        driveFifo();
        #1;
      end
      checkValue({name, " word"}, primData, words[k]);
      checkValue({name, " valid/first/last/pop"},
                 {28'd0, primValid, primFirst, primLast, fifoPop},
                 {28'd0, 1'b1, (k == 0), (k == total - 1), 1'b1});
      stepCycle();
      checkValue({name, " strobes"}, {25'd0, strobes}, (k == texIdx) ? 32'd1 : 32'd0);
      checkValue({name, " dataOut"}, fifoDataOut, words[k]);
    end
    checkValue({name, " idle after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] none[$];
    logic [31:0] quadTail[$];
    nRstGPU    = 1'b0;
    primReady  = 1'b1;
    bypassDone = 1'b0;
    driveFifo();
    repeat (2) @(posedge clk);
    #2;
    // Reset state
    checkValue("rst strobes", {25'd0, strobes}, 32'd0);
    checkValue("rst dataOut", fifoDataOut, 32'd0);
    checkValue("rst first/last/byp/busy/pop",
               {27'd0, primFirst, primLast, bypassReq, busy, fifoPop}, 32'd0);
    nRstGPU = 1'b1;
    stepCycle();

    // E5 offsets
    fifoQ.push_back(32'hE500_27FF);
    driveFifo();
    #1;
    checkValue("e5 pop", {31'd0, fifoPop}, 32'd1);
    stepCycle();
    checkValue("e5 strobe", {25'd0, strobes}, 32'h04);
    checkValue("e5 dataOut", fifoDataOut, 32'hE500_27FF);
    stepCycle();
    checkValue("e5 strobe gone", {25'd0, strobes}, 32'd0);

    // E1..E6 back-to-back
    for (int i = 0; i < 6; i++) fifoQ.push_back({8'hE1 + 8'(i), 24'h000010 + 24'(i)});
    driveFifo();
    #1;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkValue("env strobe", {25'd0, strobes}, 32'h40 >> i);
      checkValue("env dataOut", fifoDataOut, {8'hE1 + 8'(i), 24'h000010 + 24'(i)});
    end
    stepCycle();
    checkValue("env strobe end", {25'd0, strobes}, 32'd0);

    // Flat textured triangle 24h, ready stalled at word 2
    fifoQ = '{32'h2480_8080, 32'h0010_0010, 32'h7F00_1122, 32'h0020_0020,
              32'h0012_3456, 32'h0030_0030, 32'h0000_3344};
    driveFifo();
    #1;
    runPoly("tri24", 7, 4, 2, -1, none);

    // Gouraud textured quad 3Ch, FIFO runs dry before word 8
    fifoQ.delete();
    fifoQ.push_back(32'h3C11_2233);
    for (int k = 1; k < 8; k++) fifoQ.push_back(32'h0001_0000 + 32'(k));
    for (int k = 8; k < 12; k++) quadTail.push_back(32'h0001_0000 + 32'(k));
    driveFifo();
    #1;
    runPoly("quad3c", 12, 5, -1, 8, quadTail);

    // Stray bypassDone while idle is ignored
    bypassDone = 1'b1;
    stepCycle();
    bypassDone = 1'b0;
    #1;
    checkValue("stray done busy", {31'd0, busy}, 32'd0);

    // Bypass handshake
    fifoQ.push_back(32'hA000_0000);
    fifoQ.push_back(32'hE600_0003);
    driveFifo();
    #1;
    for (int c = 0; c < 20; c++) begin
      checkValue("byp req/pop", {30'd0, bypassReq, fifoPop}, 32'h2);
      stepCycle();
    end
    checkValue("byp busy", {31'd0, busy}, 32'd1);
    bypassDone = 1'b1;
    #1;
    stepCycle(1'b1);
    bypassDone = 1'b0;
    #1;
    checkValue("byp resume pop", {30'd0, bypassReq, fifoPop}, 32'h1);
    stepCycle();
    checkValue("byp e6 strobe", {25'd0, strobes}, 32'h02);
    checkValue("byp e6 dataOut", fifoDataOut, 32'hE600_0003);

    // Reset mid-polygon
    fifoQ = '{32'h2480_8080, 32'h0010_0010, 32'h7F00_1122, 32'h0020_0020,
              32'h0012_3456, 32'h0030_0030, 32'h0000_3344};
    driveFifo();
    #1;
    repeat (3) stepCycle();
    checkValue("mid busy", {31'd0, busy}, 32'd1);
    nRstGPU = 1'b0;
    #1;
    checkValue("rst mid outputs",
               {25'd0, primValid, primFirst, primLast, bypassReq, busy, fifoPop, |strobes}, 32'd0);
    checkValue("rst mid dataOut", fifoDataOut, 32'd0);
    fifoQ.delete();
    fifoQ.push_back(32'hE300_0000);
    driveFifo();
    stepCycle();
    nRstGPU = 1'b1;
    #1;
    checkValue("post rst pop", {31'd0, fifoPop}, 32'd1);
    stepCycle();
    checkValue("post rst e3", {25'd0, strobes}, 32'h10);
    checkValue("post rst dataOut", fifoDataOut, 32'hE300_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gp0_cmd_decoder.md
# gp0_cmd_decoder

GP0 command front-end. It pops 32-bit words from the GP0 command FIFO and decodes environment commands (E1h–E6h) into one-cycle load strobes with registered data; these feed the GP0 register bank directly. Polygon commands (20h–3Fh) are counted and streamed downstream word by word. While streaming, the block pulses the texture-page load on the second vertex's UV word. All other opcodes are handed off to a bypass engine through a request/done handshake.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- i_clk  in  1  clock.
- nRstGPU  in  1  reset, asynchronous, active-low.
- i_fifoEmpty  in  1  command FIFO empty.
- i_fifoData  in  32  FIFO head word (first-word-fall-through).
- o_fifoPop  out  1  pop the head word this cycle.
- fifoDataOut  out  32  registered copy of the last popped word.
- loadE5Offsets, loadTexPageE1, loadTexPage, loadTexWindowSetting, loadDrawAreaTL, loadDrawAreaBR, loadMaskSetting  out  1 each  one-cycle strobes, aligned with fifoDataOut.
- o_primValid  out  1  polygon word available downstream.
- o_primData  out  32  polygon word (equals i_fifoData).
- o_primFirst / o_primLast  out  1  command word / final word of the polygon.
- i_primReady  in  1  downstream accepts the word.
- o_bypassReq  out  1  unhandled opcode present at the FIFO head.
- i_bypassDone  in  1  one-cycle pulse: the bypass engine has consumed its command.
- o_busy  out  1  state != IDLE.

## Operation
States: IDLE, POLY, BYPASS.

IDLE, FIFO non-empty, op = i_fifoData[31:24]:
- 00h–1Fh except 02h: pop as a NOP; no strobe.
- E1h→loadTexPageE1, E2h→loadTexWindowSetting, E3h→loadDrawAreaTL, E4h→loadDrawAreaBR, E5h→loadE5Offsets, E6h→loadMaskSetting.
- E0h and E7h–FFh: pop as a NOP.
- Polygon opcodes (20h–3Fh) are decoded from bits g = op[4], q = op[3], t = op[2]:
  - n = q ? 4 : 3.
  - Total words = 1 + n·(1+t) + (n−1)·g, an integer in the range 4..12.
  - Pop only when i_primReady is high. On that pop, o_primFirst = 1, remaining ← total−1, windex ← 1, next state POLY.
- 02h and 40h–DFh: no pop; o_bypassReq = 1; next state BYPASS.

POLY:
- o_primValid = !i_fifoEmpty.
- Each accepted word (valid & ready) pops the FIFO, increments windex and decrements remaining.
- If t = 1 and windex = 4+g, loadTexPage is pulsed.
- o_primLast = 1 when remaining = 1. After the last word is accepted, next state IDLE.

BYPASS:
- o_bypassReq is held at 1 and the block never pops.
- i_bypassDone returns the state to IDLE.

Common rules:
- o_fifoPop is never asserted while i_fifoEmpty = 1.
- fifoDataOut updates on every pop, including NOPs.

## Timing
- Reset values: every strobe = 0, fifoDataOut = 0, o_primFirst = 0, o_primLast = 0, o_bypassReq = 0, o_busy = 0, state = IDLE, counters = 0.
- o_fifoPop, o_primValid, o_primData, o_primFirst, o_primLast and o_bypassReq are combinational from state and the FIFO head.
- Strobes and fifoDataOut are registered: one cycle after the pop, for exactly one cycle.
- Throughput: one word per cycle when the FIFO is non-empty and, where applicable, i_primReady is high.
- Back-to-back E-commands produce strobes on consecutive cycles.
- If i_primReady drops mid-polygon, popping stalls with no word loss; windex and remaining are held.
- FIFO empty mid-polygon: o_primValid = 0, state and counters are held.
- If i_bypassDone arrives outside BYPASS, it is ignored.
- Reset asserted mid-polygon aborts the polygon. After release, the next head word is decoded as a command.

## Structure
- Shared package gpu_cmd_pkg holds:
  - opcode constants (E1h–E6h, the polygon range, the bypass ranges);
  - the state enum (IDLE, POLY, BYPASS).
- Sub-module gp0_poly_len: combinational, op[4:2] → total word count (4 bits) and the texpage word index (3 bits).

## Test plan
- E5 offsets: E50027FFh pushed → the cycle after the pop, loadE5Offsets = 1 for one cycle with fifoDataOut = E50027FFh; no other strobe.
- E1h–E6h back-to-back, FIFO never empty → six strobes on six consecutive cycles in order. E1h pulses loadTexPageE1 only, never loadTexPage.
- Flat textured triangle, op 24h, 7 words, word 4 = 0012_3456h:
  - loadTexPage pulses only after word 4, with fifoDataOut = 00123456h;
  - o_primLast is high on word 6;
  - i_primReady low for 3 cycles at word 2 → no pops during the stall and no word loss.
- Gouraud textured quad, op 3Ch → 12 words forwarded, texpage strobe on word 5, o_primLast on word 11, then IDLE.
- Bypass: A0000000h at the head → o_bypassReq = 1 with no pop for 20 cycles. i_bypassDone pulse → next word E6000003h is popped, and loadMaskSetting fires with fifoDataOut = E6000003h.
- nRstGPU low after 3 words of op 24h → all outputs 0 immediately. After release, head word E3000000h → loadDrawAreaTL = 1.
